prog_sequencer: RTL and testbench

Run controller sitting in front of the `PC` in the CSE141L core. It accepts a program-run request, selects one of four program base addresses, and loads that address into the PC. It then enables PC advance until the decoded halt instruction arrives or a cycle budget expires, and reports completion with a done/ack handshake. It owns every PC load/advance decision outside branch resolution.

---
 rtl/prog_sequencer.sv | 130 +++++++++++++
 tb/tb_prog_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: run controller in front of the PC.
// It accepts a run request, loads one of four program base addresses into the
// PC, then lets the PC advance until a halt instruction, an abort or a cycle
// budget ends the run. Completion is reported with a done/ack handshake.
//
// Ports:
//   clk          clock
//   start        synchronous active-high reset
//   go           run request, sampled only in IDLE
//   prog_sel     program index, latched with go
//   halt_op      current instruction is halt (from decoder)
//   abort        cancel run, return to IDLE
//   ack          completion acknowledge
//   pc_load      PC loads pc_load_val this edge
//   pc_load_val  base address of the latched program
//   run_en       PC may advance/branch this edge (combinational on halt_op/abort)
//   busy         state is LOAD or RUN
//   done         state is DONE
//   timeout      last run ended by budget, not by halt
//   cycle_count  RUN cycles executed in the current/last run
module prog_sequencer #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned BASE0   = 0,
  parameter int unsigned BASE1   = 65,
  parameter int unsigned BASE2   = 130,
  parameter int unsigned BASE3   = 195
) (
  input  logic             clk,
  input  logic             start,
  input  logic             go,
  input  logic [1:0]       prog_sel,
  input  logic             halt_op,
  input  logic             abort,
  input  logic             ack,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // State and run bookkeeping registers
  always_ff @(posedge clk) begin
    if (start) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; RUN exits are prioritised abort > halt > budget
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          sel_d     = prog_sel;
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (halt_op) begin
          // Halt cycle does not count: the PC holds on the halt instruction
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = CNT_MAX;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decodes
  always_comb begin
    pc_load     = (state_q == ST_LOAD);
    run_en      = (state_q == ST_RUN) && !halt_op && !abort;
    busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    done        = (state_q == ST_DONE);
    timeout     = timeout_q;
    cycle_count = cnt_q;
    case (sel_q)
      2'd0:    pc_load_val = PC_W'(BASE0);
      2'd1:    pc_load_val = PC_W'(BASE1);
      2'd2:    pc_load_val = PC_W'(BASE2);
      default: pc_load_val = PC_W'(BASE3);
    endcase
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: instance a uses the default budget,
// instance b uses TIMEOUT=8. Inputs change 1ns after the rising edge and
// outputs are checked 1ns later, so each check sees one cycle's state.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        start;
  logic        go_a, halt_a, abort_a, ack_a;
  logic [1:0]  sel_a;
  logic        go_b, halt_b, abort_b, ack_b;
  logic [1:0]  sel_b;

  logic        pc_load_a, run_en_a, busy_a, done_a, timeout_a;
  logic [9:0]  pc_val_a;
  logic [15:0] cnt_a;
  logic        pc_load_b, run_en_b, busy_b, done_b, timeout_b;
  logic [9:0]  pc_val_b;
  logic [15:0] cnt_b;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  prog_sequencer dut_a (
    .clk(clk), .start(start), .go(go_a), .prog_sel(sel_a), .halt_op(halt_a),
    .abort(abort_a), .ack(ack_a), .pc_load(pc_load_a), .pc_load_val(pc_val_a),
    .run_en(run_en_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .cycle_count(cnt_a)
  );

  prog_sequencer #(.TIMEOUT(8)) dut_b (
    .clk(clk), .start(start), .go(go_b), .prog_sel(sel_b), .halt_op(halt_b),
    .abort(abort_b), .ack(ack_b), .pc_load(pc_load_b), .pc_load_val(pc_val_b),
    .run_en(run_en_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .cycle_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    start = 1'b1;
    go_a = 0; halt_a = 0; abort_a = 0; ack_a = 0; sel_a = 0;
    go_b = 0; halt_b = 0; abort_b = 0; ack_b = 0; sel_b = 0;
    tick(); tick();
    start = 1'b0;
    #1;
    chk("rst_pc_load", pc_load_a, 0);
    chk("rst_run_en",  run_en_a, 0);
    chk("rst_busy",    busy_a, 0);
    chk("rst_done",    done_a, 0);
    chk("rst_pc_val",  pc_val_a, 0);
    chk("rst_timeout", timeout_a, 0);
    chk("rst_count",   cnt_a, 0);

    // Run program 1, halt after 12 non-halt cycles
    go_a = 1; sel_a = 2'd1;
    tick();
    go_a = 0; #1;
    chk("load_pc_load", pc_load_a, 1);
    chk("load_pc_val",  pc_val_a, 65);
    chk("load_busy",    busy_a, 1);
    chk("load_run_en",  run_en_a, 0);
    tick();
    chk("run1_pc_load", pc_load_a, 0);
    chk("run1_run_en",  run_en_a, 1);
    chk("run1_busy",    busy_a, 1);
    repeat (12) tick();
    halt_a = 1; #1;
    chk("halt_run_en", run_en_a, 0);
    chk("halt_count",  cnt_a, 12);
    tick();
    halt_a = 0; #1;
    chk("halt_done",    done_a, 1);
    chk("halt_busy",    busy_a, 0);
    chk("halt_timeout", timeout_a, 0);
    chk("halt_count2",  cnt_a, 12);
    // go and abort in DONE are ignored
    go_a = 1; sel_a = 2'd2; abort_a = 1;
    tick();
    go_a = 0; abort_a = 0; #1;
    chk("done_hold",    done_a, 1);
    chk("done_sel_kept", pc_val_a, 65);
    ack_a = 1;
    tick();
    ack_a = 0; #1;
    chk("ack_done", done_a, 0);
    chk("ack_busy", busy_a, 0);
    chk("ack_load", pc_load_a, 0);

    // Program 3, go during LOAD ignored, abort+halt in RUN cycle 5
    go_a = 1; sel_a = 2'd3;
    tick();
    sel_a = 2'd0; #1;
    chk("p3_pc_val", pc_val_a, 195);
    tick();
    go_a = 0; #1;
    chk("p3_run_en", run_en_a, 1);
    chk("p3_sel_kept", pc_val_a, 195);
    repeat (4) tick();
    abort_a = 1; halt_a = 1; #1;
    chk("abort_run_en", run_en_a, 0);
    tick();
    abort_a = 0; halt_a = 0; #1;
    chk("abort_busy",    busy_a, 0);
    chk("abort_done",    done_a, 0);
    chk("abort_count",   cnt_a, 4);
    chk("abort_timeout", timeout_a, 0);
    tick();
    chk("abort_nodone", done_a, 0);

    // Reset mid-run with go asserted
    go_a = 1; sel_a = 2'd2;
    tick();
    go_a = 0;
    tick(); tick();
    chk("mid_count", cnt_a, 1);
    start = 1; go_a = 1;
    tick();
    start = 0; go_a = 0; #1;
    chk("mrst_pc_val", pc_val_a, 0);
    chk("mrst_count",  cnt_a, 0);
    chk("mrst_busy",   busy_a, 0);
    chk("mrst_run_en", run_en_a, 0);
    chk("mrst_load",   pc_load_a, 0);
    tick();
    chk("mrst_idle", busy_a, 0);

    // TIMEOUT=8: budget expiry
    go_b = 1; sel_b = 2'd0;
    tick();
    go_b = 0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("to_run_en_%0d", i), run_en_b, 1);
      tick();
    end
    chk("to_done",    done_b, 1);
    chk("to_timeout", timeout_b, 1);
    chk("to_count",   cnt_b, 8);
    chk("to_run_en",  run_en_b, 0);
    ack_b = 1;
    tick();
    ack_b = 0; #1;
    chk("to_ack_done", done_b, 0);
    chk("to_ack_timeout_kept", timeout_b, 1);

    // TIMEOUT=8: halt on the budget cycle wins
    go_b = 1; sel_b = 2'd2;
    tick();
    go_b = 0; #1;
    chk("b_load_timeout_clr", timeout_b, 0);
    chk("b_load_pc_val", pc_val_b, 130);
    tick();
    repeat (7) tick();
    chk("b_cyc8_count", cnt_b, 7);
    halt_b = 1; #1;
    chk("b_halt_run_en", run_en_b, 0);
    tick();
    halt_b = 0; #1;
    chk("b_halt_done",    done_b, 1);
    chk("b_halt_timeout", timeout_b, 0);
    chk("b_halt_count",   cnt_b, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
